bch_syndrome: RTL and testbench



---
 rtl/bch_syndrome_pkg.sv | 76 +++++++
 rtl/bch_syndrome_lane.sv | 51 +++++
 rtl/bch_syndrome.sv | 107 ++++++++++
 tb/tb_bch_syndrome.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_syndrome_pkg.sv
// BCH syndrome helpers: GF(2^M) constants, multiply/fold matrices, FSM encodings.
// Shared by bch_syndrome and bch_syndrome_lane via import bch_syndrome_pkg::*.
package bch_syndrome_pkg;

    localparam int MAXM = 16;
    localparam int MAXB = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Default primitive polynomial for GF(2^m), including the x^m term.
    function automatic logic [MAXM:0] prim_poly(input int m);
        logic [MAXM:0] p;
        case (m)
            2:       p = 17'h00007;
            3:       p = 17'h0000B;
            4:       p = 17'h00013;
            5:       p = 17'h00025;
            6:       p = 17'h00043;
            7:       p = 17'h00083;
            8:       p = 17'h0011D;
            9:       p = 17'h00211;
            10:      p = 17'h00409;
            11:      p = 17'h00805;
            12:      p = 17'h01053;
            13:      p = 17'h0201B;
            14:      p = 17'h04443;
            15:      p = 17'h08003;
            16:      p = 17'h1100B;
            default: p = 17'h00013;
        endcase
        return p;
    endfunction

    function automatic logic [MAXM-1:0] mul_alpha(input int m,
                                                  input logic [MAXM-1:0] v);
        logic [MAXM:0] t;
        t = {v, 1'b0};
        if (t[m])
            t = t ^ prim_poly(m);
        return t[MAXM-1:0];
    endfunction

    function automatic logic [MAXM-1:0] alpha_pow(input int m, input int k);
        logic [MAXM-1:0] v;
        int e;
        e = k % ((1 << m) - 1);
        v = MAXM'(1);
        for (int i = 0; i < e; i++)
            v = mul_alpha(m, v);
        return v;
    endfunction

    // Column i = alpha^(k+i): multiplies an m-bit element by alpha^k.
    function automatic logic [MAXM*MAXM-1:0] mul_matrix(input int m,
                                                        input int k);
        logic [MAXM*MAXM-1:0] mat;
        mat = '0;
        for (int i = 0; i < m; i++)
            mat[i*MAXM +: MAXM] = alpha_pow(m, k + i);
        return mat;
    endfunction

    // Column b = alpha^(j*b): folds one beat of input bits into syndrome j.
    function automatic logic [MAXM*MAXB-1:0] fold_matrix(input int m,
                                                         input int j,
                                                         input int bits);
        logic [MAXM*MAXB-1:0] mat;
        mat = '0;
        for (int b = 0; b < bits; b++)
            mat[b*MAXM +: MAXM] = alpha_pow(m, j * b);
        return mat;
    endfunction

endpackage

// File: rtl/bch_syndrome_lane.sv
// One syndrome accumulator S_J: S <= S*alpha^(J*BITS) ^ fold(data).
// Ports: clk, reset_n, i_clr, i_en, i_data, o_syn, o_next (BCH_SYNDROME_ERR_FLAG_EN).
module bch_syndrome_lane
    import bch_syndrome_pkg::*;
#(
    parameter int M    = 4,
    parameter int BITS = 1,
    parameter int J    = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [BITS-1:0] i_data,
`ifdef BCH_SYNDROME_ERR_FLAG_EN
    output logic [M-1:0]    o_next,
`endif
    output logic [M-1:0]    o_syn
);

    localparam logic [MAXM*MAXM-1:0] C_MUL  = mul_matrix(M, J * BITS);
    localparam logic [MAXM*MAXB-1:0] C_FOLD = fold_matrix(M, J, BITS);

    logic [M-1:0] r_acc;
    logic [M-1:0] w_next;

    always_comb begin
        w_next = '0;
        for (int i = 0; i < M; i++)
            if (r_acc[i])
                w_next = w_next ^ C_MUL[i*MAXM +: M];
        for (int b = 0; b < BITS; b++)
            if (i_data[b])
                w_next = w_next ^ C_FOLD[b*MAXM +: M];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= w_next;
    end

    assign o_syn = r_acc;
`ifdef BCH_SYNDROME_ERR_FLAG_EN
    assign o_next = w_next;
`endif

endmodule

// File: rtl/bch_syndrome.sv
// BCH odd-syndrome calculator, BITS bits per beat, MSB-first codeword.
// Ports: start, in_valid/in_ready/data_in, out_valid/out_ready/syndromes, busy;
// out_err added when BCH_SYNDROME_ERR_FLAG_EN is defined.
module bch_syndrome
    import bch_syndrome_pkg::*;
#(
    parameter int M    = 4,
    parameter int N    = 15,
    parameter int T    = 2,
    parameter int BITS = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] data_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [M*T-1:0]  syndromes,
`ifdef BCH_SYNDROME_ERR_FLAG_EN
    output logic            out_err,
`endif
    output logic            busy
);

    localparam int BEATS = N / BITS;
    localparam int CW    = $clog2(BEATS + 1);

    if (N % BITS != 0) begin : g_bits_chk
        $error("bch_syndrome: N must be a multiple of BITS");
    end
    if (N > (1 << M) - 1 || M > MAXM || BITS > MAXB) begin : g_size_chk
        $error("bch_syndrome: unsupported M/N/BITS");
    end

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          w_clr;
    logic          w_beat;
    logic          w_last;

    assign w_clr  = (r_state == ST_IDLE) && start;
    assign w_beat = (r_state == ST_ACCUM) && in_valid;
    assign w_last = w_beat && (r_cnt == CW'(BEATS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state <= ST_ACCUM;
                    r_cnt   <= '0;
                end
                ST_ACCUM: if (w_last) begin
                    r_state <= ST_HOLD;
                    r_cnt   <= '0;
                end else if (w_beat) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                ST_HOLD: if (out_ready)
                    r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BCH_SYNDROME_ERR_FLAG_EN
    logic [M*T-1:0] w_next;
`endif

    for (genvar k = 0; k < T; k++) begin : g_lane
        bch_syndrome_lane #(
            .M    (M),
            .BITS (BITS),
            .J    (2 * k + 1)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .i_clr   (w_clr),
            .i_en    (w_beat),
            .i_data  (data_in),
`ifdef BCH_SYNDROME_ERR_FLAG_EN
            .o_next  (w_next[M*k +: M]),
`endif
            .o_syn   (syndromes[M*k +: M])
        );
    end

`ifdef BCH_SYNDROME_ERR_FLAG_EN
    logic r_err;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_err <= 1'b0;
        else if (w_last)
            r_err <= |w_next;
    end
    assign out_err = r_err;
`endif

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bch_syndrome.sv
// Directed self-checking bench for bch_syndrome (BITS=1 and BITS=3 instances).
// Expected syndromes are hand-computed in GF(16), x^4+x+1.
module tb_bch_syndrome;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       start1 = 0, in_valid1 = 0, out_ready1 = 0;
    logic [0:0] data1 = '0;
    logic       in_ready1, out_valid1, busy1;
    logic [7:0] syn1;

    logic       start3 = 0, in_valid3 = 0, out_ready3 = 0;
    logic [2:0] data3 = '0;
    logic       in_ready3, out_valid3, busy3;
    logic [7:0] syn3;

`ifdef BCH_SYNDROME_ERR_FLAG_EN
    logic       err1, err3;
`endif

    always #5 clk = ~clk;

    bch_syndrome #(.M(4), .N(15), .T(2), .BITS(1)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .data_in   (data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .syndromes (syn1),
`ifdef BCH_SYNDROME_ERR_FLAG_EN
        .out_err   (err1),
`endif
        .busy      (busy1)
    );

    bch_syndrome #(.M(4), .N(15), .T(2), .BITS(3)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .data_in   (data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .syndromes (syn3),
`ifdef BCH_SYNDROME_ERR_FLAG_EN
        .out_err   (err3),
`endif
        .busy      (busy3)
    );

    // Drives one codeword into dut1, MSB (x^14) first; ends at the negedge
    // after the final accepted beat.
    task automatic run1(input logic [14:0] cw, input bit gaps, output bit ok);
        int i;
        int n;
        @(negedge clk);
        start1 = 1;
        @(negedge clk);
        start1 = 0;
        i = 14;
        n = 0;
        while (i >= 0 && n < 200) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid1 = 0;
                data1 = 1'b1;
            end else begin
                in_valid1 = 1;
                data1 = cw[i];
            end
            if (in_valid1 && in_ready1)
                i--;
            @(negedge clk);
            n++;
        end
        in_valid1 = 0;
        data1 = '0;
        ok = (i < 0);
    endtask

    task automatic hs1();
        out_ready1 = 1;
        @(negedge clk);
        out_ready1 = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready1, out_valid1, busy1, syn1} !== 11'h0) begin
            errors++;
            $display("FAIL reset1: got rdy=%b ov=%b busy=%b syn=%h want 0",
                     in_ready1, out_valid1, busy1, syn1);
        end
        checks++;
        if ({in_ready3, out_valid3, busy3, syn3} !== 11'h0) begin
            errors++;
            $display("FAIL reset3: got rdy=%b ov=%b busy=%b syn=%h want 0",
                     in_ready3, out_valid3, busy3, syn3);
        end
        reset_n = 1;
    endtask

    task automatic test_zero();
        bit ok;
        run1(15'h0, 0, ok);
        checks++;
        if (!ok || out_valid1 !== 1'b1 || syn1 !== 8'h00) begin
            errors++;
            $display("FAIL zero: ok=%b ov=%b syn=%h want ov=1 syn=00",
                     ok, out_valid1, syn1);
        end
`ifdef BCH_SYNDROME_ERR_FLAG_EN
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL zero_err: got %b want 0", err1);
        end
`endif
        hs1();
        checks++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL zero_hs: ov=%b busy=%b want 0 0",
                     out_valid1, busy1);
        end
    endtask

    task automatic test_single();
        logic [14:0] cw [4];
        logic [7:0]  ex [4];
        bit ok;
        cw[0] = 15'h0001; ex[0] = 8'h11;
        cw[1] = 15'h0002; ex[1] = 8'h82;
        cw[2] = 15'h4000; ex[2] = 8'hF9;
        cw[3] = 15'h4002; ex[3] = 8'h7B;
        for (int k = 0; k < 4; k++) begin
            run1(cw[k], 0, ok);
            checks++;
            if (!ok || out_valid1 !== 1'b1 || syn1 !== ex[k]) begin
                errors++;
                $display("FAIL single%0d: ok=%b ov=%b syn=%h want ov=1 %h",
                         k, ok, out_valid1, syn1, ex[k]);
            end
`ifdef BCH_SYNDROME_ERR_FLAG_EN
            checks++;
            if (err1 !== 1'b1) begin
                errors++;
                $display("FAIL single%0d_err: got %b want 1", k, err1);
            end
`endif
            hs1();
            checks++;
            if (out_valid1 !== 1'b0 || syn1 !== ex[k]) begin
                errors++;
                $display("FAIL single%0d_idle: ov=%b syn=%h want 0 %h",
                         k, out_valid1, syn1, ex[k]);
            end
        end
    endtask

    task automatic test_gaps_hold();
        bit ok;
        run1(15'h4002, 1, ok);
        checks++;
        if (!ok || syn1 !== 8'h7B) begin
            errors++;
            $display("FAIL gaps: ok=%b syn=%h want 7b", ok, syn1);
        end
        for (int c = 0; c < 5; c++) begin
            start1 = 1;
            @(negedge clk);
            checks++;
            if (out_valid1 !== 1'b1 || syn1 !== 8'h7B) begin
                errors++;
                $display("FAIL hold%0d: ov=%b syn=%h want 1 7b",
                         c, out_valid1, syn1);
            end
        end
        start1 = 0;
        hs1();
        checks++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_hs: ov=%b busy=%b want 0 0",
                     out_valid1, busy1);
        end
    endtask

    task automatic test_bits3();
        logic [14:0] cw;
        int k;
        int n;
        cw = 15'h4000;
        @(negedge clk);
        start3 = 1;
        @(negedge clk);
        start3 = 0;
        k = 4;
        n = 0;
        while (k >= 0 && n < 100) begin
            in_valid3 = 1;
            data3 = cw[3*k +: 3];
            if (in_ready3)
                k--;
            @(negedge clk);
            n++;
        end
        in_valid3 = 0;
        data3 = '0;
        checks++;
        if (k >= 0 || out_valid3 !== 1'b1 || syn3 !== 8'hF9) begin
            errors++;
            $display("FAIL bits3: left=%0d ov=%b syn=%h want ov=1 f9",
                     k + 1, out_valid3, syn3);
        end
        out_ready3 = 1;
        @(negedge clk);
        out_ready3 = 0;
        checks++;
        if (out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL bits3_hs: ov=%b busy=%b want 0 0",
                     out_valid3, busy3);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        start1 = 1;
        @(negedge clk);
        start1 = 0;
        for (int b = 0; b < 7; b++) begin
            in_valid1 = 1;
            data1 = 1'b1;
            @(negedge clk);
        end
        in_valid1 = 0;
        checks++;
        if (busy1 !== 1'b1 || syn1 === 8'h00) begin
            errors++;
            $display("FAIL mid_pre: busy=%b syn=%h want busy=1 syn!=0",
                     busy1, syn1);
        end
        reset_n = 0;
        #1;
        checks++;
        if ({in_ready1, out_valid1, busy1, syn1} !== 11'h0) begin
            errors++;
            $display("FAIL mid_rst: rdy=%b ov=%b busy=%b syn=%h want 0",
                     in_ready1, out_valid1, busy1, syn1);
        end
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        checks++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle: ov=%b busy=%b want 0 0",
                     out_valid1, busy1);
        end
        run1(15'h0, 0, ok);
        checks++;
        if (!ok || out_valid1 !== 1'b1 || syn1 !== 8'h00) begin
            errors++;
            $display("FAIL mid_clean: ok=%b ov=%b syn=%h want ov=1 00",
                     ok, out_valid1, syn1);
        end
        hs1();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single();
        test_gaps_hold();
        test_bits3();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time %0t exceeded bound", $time);
        $fatal(1);
    end

endmodule
